// File: rtl/testblock_core.sv
// rtl/testblock_core.sv - testblock user logic: CtrlPort registers, complex-gain payload pipeline, context pass-through
module testblock_core #(
  parameter int          CHDR_W   = 64,
  parameter logic [15:0] GAIN_RST = 16'h4000,
  parameter logic [31:0] COMPAT   = 32'h0001_0000
) (
  input  logic              axis_data_clk,
  input  logic              axis_data_rst,
  input  logic              s_ctrlport_req_wr,
  input  logic              s_ctrlport_req_rd,
  input  logic [19:0]       s_ctrlport_req_addr,
  input  logic [31:0]       s_ctrlport_req_data,
  output logic              s_ctrlport_resp_ack,
  output logic [31:0]       s_ctrlport_resp_data,
  input  logic [31:0]       s_in_payload_tdata,
  input  logic              s_in_payload_tkeep,
  input  logic              s_in_payload_tlast,
  input  logic              s_in_payload_tvalid,
  output logic              s_in_payload_tready,
  input  logic [CHDR_W-1:0] s_in_context_tdata,
  input  logic [3:0]        s_in_context_tuser,
  input  logic              s_in_context_tlast,
  input  logic              s_in_context_tvalid,
  output logic              s_in_context_tready,
  output logic [31:0]       m_out_payload_tdata,
  output logic              m_out_payload_tkeep,
  output logic              m_out_payload_tlast,
  output logic              m_out_payload_tvalid,
  input  logic              m_out_payload_tready,
  output logic [CHDR_W-1:0] m_out_context_tdata,
  output logic [3:0]        m_out_context_tuser,
  output logic              m_out_context_tlast,
  output logic              m_out_context_tvalid,
  input  logic              m_out_context_tready
);

  localparam logic [19:0] ADDR_GAIN   = 20'h00000;
  localparam logic [19:0] ADDR_CTRL   = 20'h00004;
  localparam logic [19:0] ADDR_PKTCNT = 20'h00008;
  localparam logic [19:0] ADDR_COMPAT = 20'h0000C;

  logic        r_ack;
  logic [31:0] r_rdata;
  logic [15:0] r_gain;
  logic        r_bypass;
  logic [31:0] r_pkt_count;
  logic [31:0] w_rd_mux;

  logic        r_sop;
  logic [15:0] r_active_gain;
  logic        r_active_bypass;
  logic [15:0] w_gain_sel;
  logic        w_bypass_sel;

  logic               w_en;
  logic               w_in_hs;
  logic               w_out_hs;
  logic signed [31:0] w_in_i;
  logic signed [31:0] w_in_q;
  logic signed [31:0] w_gain_ext;

  logic               r_v1;
  logic signed [31:0] r_prod_i;
  logic signed [31:0] r_prod_q;
  logic [31:0]        r_s1_raw;
  logic               r_s1_bypass;
  logic               r_s1_keep;
  logic               r_s1_last;
  logic signed [31:0] w_rnd_i;
  logic signed [31:0] w_rnd_q;

  logic              r_v2;
  logic [31:0]       r_s2_data;
  logic              r_s2_keep;
  logic              r_s2_last;

  logic              r_cv;
  logic [CHDR_W-1:0] r_c_data;
  logic [3:0]        r_c_user;
  logic              r_c_last;
  logic              w_c_en;

  logic w_unused;
  assign w_unused = ^s_ctrlport_req_data[31:16];

  function automatic logic [15:0] sat16(input logic signed [31:0] v);
    if (v > 32'sd32767)
      return 16'h7FFF;
    else if (v < -32'sd32768)
      return 16'h8000;
    else
      return v[15:0];
  endfunction

  always_comb begin
    w_rd_mux = 32'h0;
    case (s_ctrlport_req_addr)
      ADDR_GAIN:   w_rd_mux = {16'h0, r_gain};
      ADDR_CTRL:   w_rd_mux = {31'h0, r_bypass};
      ADDR_PKTCNT: w_rd_mux = r_pkt_count;
      ADDR_COMPAT: w_rd_mux = COMPAT;
      default:     w_rd_mux = 32'h0;
    endcase
  end

  // Read data is sampled before the write lands, so a combined wr+rd returns the old value.
  always_ff @(posedge axis_data_clk or posedge axis_data_rst) begin
    if (axis_data_rst) begin
      r_ack    <= 1'b0;
      r_rdata  <= 32'h0;
      r_gain   <= GAIN_RST;
      r_bypass <= 1'b0;
    end else begin
      r_ack   <= s_ctrlport_req_wr | s_ctrlport_req_rd;
      r_rdata <= s_ctrlport_req_rd ? w_rd_mux : 32'h0;
      if (s_ctrlport_req_wr) begin
        if (s_ctrlport_req_addr == ADDR_GAIN)
          r_gain <= s_ctrlport_req_data[15:0];
        if (s_ctrlport_req_addr == ADDR_CTRL)
          r_bypass <= s_ctrlport_req_data[0];
      end
    end
  end

  assign w_out_hs = r_v2 & m_out_payload_tready;

  always_ff @(posedge axis_data_clk or posedge axis_data_rst) begin
    if (axis_data_rst)
      r_pkt_count <= 32'h0;
    else if (s_ctrlport_req_wr && (s_ctrlport_req_addr == ADDR_PKTCNT))
      r_pkt_count <= 32'h0;
    else if (w_out_hs && r_s2_last)
      r_pkt_count <= r_pkt_count + 32'h1;
  end

  assign w_en    = ~r_v2 | m_out_payload_tready;
  assign w_in_hs = s_in_payload_tvalid & s_in_payload_tready;

  // The first beat of a packet must already see the freshly latched settings.
  assign w_gain_sel   = r_sop ? r_gain   : r_active_gain;
  assign w_bypass_sel = r_sop ? r_bypass : r_active_bypass;

  always_ff @(posedge axis_data_clk or posedge axis_data_rst) begin
    if (axis_data_rst) begin
      r_sop           <= 1'b1;
      r_active_gain   <= GAIN_RST;
      r_active_bypass <= 1'b0;
    end else if (w_in_hs) begin
      r_sop <= s_in_payload_tlast;
      if (r_sop) begin
        r_active_gain   <= r_gain;
        r_active_bypass <= r_bypass;
      end
    end
  end

  assign w_in_i     = {{16{s_in_payload_tdata[31]}}, s_in_payload_tdata[31:16]};
  assign w_in_q     = {{16{s_in_payload_tdata[15]}}, s_in_payload_tdata[15:0]};
  assign w_gain_ext = {{16{w_gain_sel[15]}}, w_gain_sel};

  always_ff @(posedge axis_data_clk or posedge axis_data_rst) begin
    if (axis_data_rst) begin
      r_v1        <= 1'b0;
      r_prod_i    <= 32'sh0;
      r_prod_q    <= 32'sh0;
      r_s1_raw    <= 32'h0;
      r_s1_bypass <= 1'b0;
      r_s1_keep   <= 1'b0;
      r_s1_last   <= 1'b0;
    end else if (w_en) begin
      r_v1 <= s_in_payload_tvalid;
      if (s_in_payload_tvalid) begin
        r_prod_i    <= w_in_i * w_gain_ext;
        r_prod_q    <= w_in_q * w_gain_ext;
        r_s1_raw    <= s_in_payload_tdata;
        r_s1_bypass <= w_bypass_sel;
        r_s1_keep   <= s_in_payload_tkeep;
        r_s1_last   <= s_in_payload_tlast;
      end
    end
  end

  // Q1.14 product back to Q15 with round-half-up.
  assign w_rnd_i = (r_prod_i + 32'sd8192) >>> 14;
  assign w_rnd_q = (r_prod_q + 32'sd8192) >>> 14;

  always_ff @(posedge axis_data_clk or posedge axis_data_rst) begin
    if (axis_data_rst) begin
      r_v2      <= 1'b0;
      r_s2_data <= 32'h0;
      r_s2_keep <= 1'b0;
      r_s2_last <= 1'b0;
    end else if (w_en) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_s2_data <= r_s1_bypass ? r_s1_raw : {sat16(w_rnd_i), sat16(w_rnd_q)};
        r_s2_keep <= r_s1_keep;
        r_s2_last <= r_s1_last;
      end
    end
  end

  assign w_c_en = ~r_cv | m_out_context_tready;

  always_ff @(posedge axis_data_clk or posedge axis_data_rst) begin
    if (axis_data_rst) begin
      r_cv     <= 1'b0;
      r_c_data <= '0;
      r_c_user <= 4'h0;
      r_c_last <= 1'b0;
    end else if (w_c_en) begin
      r_cv <= s_in_context_tvalid;
      if (s_in_context_tvalid) begin
        r_c_data <= s_in_context_tdata;
        r_c_user <= s_in_context_tuser;
        r_c_last <= s_in_context_tlast;
      end
    end
  end

  assign s_ctrlport_resp_ack  = r_ack;
  assign s_ctrlport_resp_data = r_rdata;
  // Readies are forced low while reset is held so every output reads 0.
  assign s_in_payload_tready  = w_en & ~axis_data_rst;
  assign s_in_context_tready  = w_c_en & ~axis_data_rst;
  assign m_out_payload_tdata  = r_s2_data;
  assign m_out_payload_tkeep  = r_s2_keep;
  assign m_out_payload_tlast  = r_s2_last;
  assign m_out_payload_tvalid = r_v2;
  assign m_out_context_tdata  = r_c_data;
  assign m_out_context_tuser  = r_c_user;
  assign m_out_context_tlast  = r_c_last;
  assign m_out_context_tvalid = r_cv;

endmodule

// File: tb/tb_testblock_core.sv
// tb/tb_testblock_core.sv - scoreboard bench for testblock_core
module tb_testblock_core;
  localparam int CW = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_wr, req_rd;
  logic [19:0]   req_addr;
  logic [31:0]   req_data;
  logic          resp_ack;
  logic [31:0]   resp_data;
  logic [31:0]   s_pdata;
  logic          s_pkeep, s_plast, s_pvalid, s_pready;
  logic [CW-1:0] s_cdata;
  logic [3:0]    s_cuser;
  logic          s_clast, s_cvalid, s_cready;
  logic [31:0]   m_pdata;
  logic          m_pkeep, m_plast, m_pvalid, m_pready;
  logic [CW-1:0] m_cdata;
  logic [3:0]    m_cuser;
  logic          m_clast, m_cvalid, m_cready;

  testblock_core #(.CHDR_W(CW)) dut (
    .axis_data_clk(clk), .axis_data_rst(rst),
    .s_ctrlport_req_wr(req_wr), .s_ctrlport_req_rd(req_rd),
    .s_ctrlport_req_addr(req_addr), .s_ctrlport_req_data(req_data),
    .s_ctrlport_resp_ack(resp_ack), .s_ctrlport_resp_data(resp_data),
    .s_in_payload_tdata(s_pdata), .s_in_payload_tkeep(s_pkeep),
    .s_in_payload_tlast(s_plast), .s_in_payload_tvalid(s_pvalid),
    .s_in_payload_tready(s_pready),
    .s_in_context_tdata(s_cdata), .s_in_context_tuser(s_cuser),
    .s_in_context_tlast(s_clast), .s_in_context_tvalid(s_cvalid),
    .s_in_context_tready(s_cready),
    .m_out_payload_tdata(m_pdata), .m_out_payload_tkeep(m_pkeep),
    .m_out_payload_tlast(m_plast), .m_out_payload_tvalid(m_pvalid),
    .m_out_payload_tready(m_pready),
    .m_out_context_tdata(m_cdata), .m_out_context_tuser(m_cuser),
    .m_out_context_tlast(m_clast), .m_out_context_tvalid(m_cvalid),
    .m_out_context_tready(m_cready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mdl(input logic [15:0] x, input logic [15:0] g);
    longint p;
    p = longint'($signed(x)) * longint'($signed(g)) + 64'sd8192;
    p = p >>> 14;
    if (p > 32767)  return 16'h7FFF;
    if (p < -32768) return 16'h8000;
    return p[15:0];
  endfunction

  typedef struct { logic [33:0] d; int cyc; } pent_t;
  pent_t       q_pay[$];
  logic [68:0] q_ctx[$];

  int          cyc = 0;
  int          in_beats = 0;
  bit          chk_lat = 0;
  logic [15:0] m_gain = 16'h4000;
  logic        m_byp = 1'b0;
  logic [15:0] m_act_gain = 16'h4000;
  logic        m_act_byp = 1'b0;
  logic        m_sop = 1'b1;
  int          rdy_mode = 0;
  int          crdy_mode = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       m_pready = 1'b1;
      1:       m_pready = 1'($urandom_range(0, 1));
      default: m_pready = 1'b0;
    endcase
    m_cready = (crdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
  end

  // Expected-value side: model applies settings latched at packet start.
  always @(negedge clk) begin
    pent_t e;
    if (rst) begin
      m_sop = 1'b1;
    end else begin
      if (s_pvalid && s_pready) begin
        if (m_sop) begin
          m_act_gain = m_gain;
          m_act_byp  = m_byp;
        end
        e.d = {s_pkeep, s_plast, m_act_byp ? s_pdata :
               {mdl(s_pdata[31:16], m_act_gain), mdl(s_pdata[15:0], m_act_gain)}};
        e.cyc = cyc;
        q_pay.push_back(e);
        in_beats++;
        m_sop = s_plast;
      end
      if (s_cvalid && s_cready)
        q_ctx.push_back({s_clast, s_cuser, s_cdata});
    end
  end

  always @(negedge clk) begin
    pent_t e;
    if (!rst) begin
      if (m_pvalid && m_pready) begin
        if (q_pay.size() == 0) chk("pay_unexpected", 1, 0);
        else begin
          e = q_pay.pop_front();
          chk("pay", {m_pkeep, m_plast, m_pdata}, e.d);
          if (chk_lat) chk("latency", cyc - e.cyc, 2);
        end
      end
      if (m_cvalid && m_cready) begin
        if (q_ctx.size() == 0) chk("ctx_unexpected", 1, 0);
        else chk("ctx", {m_clast, m_cuser, m_cdata}, q_ctx.pop_front());
      end
    end
  end

  task automatic ctrl_write(input logic [19:0] a, input logic [31:0] d);
    req_wr = 1'b1; req_addr = a; req_data = d;
    @(posedge clk); #1;
    req_wr = 1'b0;
    if (a == 20'h0) m_gain = d[15:0];
    if (a == 20'h4) m_byp  = d[0];
    chk("wr_ack", resp_ack, 1);
    chk("wr_data", resp_data, 0);
  endtask

  task automatic ctrl_read(input logic [19:0] a, input logic [31:0] exp, input string tag);
    req_rd = 1'b1; req_addr = a;
    @(posedge clk); #1;
    req_rd = 1'b0;
    chk({tag, "_ack"}, resp_ack, 1);
    chk(tag, resp_data, exp);
  endtask

  task automatic wait_pay_hs();
    bit hs;
    int t = 0;
    do begin
      @(negedge clk);
      hs = s_pvalid && s_pready;
      @(posedge clk); #1;
      t++;
    end while (!hs && t < 500);
    if (!hs) chk("pay_in_timeout", 0, 1);
  endtask

  task automatic send_pkt(input int n, input logic [31:0] item, input bit rnd);
    for (int b = 0; b < n; b++) begin
      if (rnd) while ($urandom_range(0, 3) == 0) begin
        s_pvalid = 1'b0; @(posedge clk); #1;
      end
      s_pdata  = rnd ? $urandom : item;
      s_pkeep  = 1'b1;
      s_plast  = (b == n - 1);
      s_pvalid = 1'b1;
      wait_pay_hs();
    end
    s_pvalid = 1'b0; s_plast = 1'b0;
  endtask

  task automatic send_ctx(input int n);
    bit hs;
    int t;
    for (int b = 0; b < n; b++) begin
      while ($urandom_range(0, 2) == 0) begin
        s_cvalid = 1'b0; @(posedge clk); #1;
      end
      s_cdata  = {$urandom, $urandom};
      s_cuser  = 4'($urandom_range(0, 15));
      s_clast  = 1'($urandom_range(0, 1));
      s_cvalid = 1'b1;
      t = 0;
      do begin
        @(negedge clk);
        hs = s_cvalid && s_cready;
        @(posedge clk); #1;
        t++;
      end while (!hs && t < 500);
      if (!hs) chk("ctx_in_timeout", 0, 1);
    end
    s_cvalid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((q_pay.size() != 0 || q_ctx.size() != 0) && t < 300) begin
      @(posedge clk); #1; t++;
    end
    chk("drain_pay", q_pay.size(), 0);
    chk("drain_ctx", q_ctx.size(), 0);
  endtask

  initial begin
    int base, t;
    req_wr = 0; req_rd = 0; req_addr = 0; req_data = 0;
    s_pdata = 0; s_pkeep = 0; s_plast = 0; s_pvalid = 0;
    s_cdata = 0; s_cuser = 0; s_clast = 0; s_cvalid = 0;
    m_pready = 1; m_cready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pvalid", m_pvalid, 0);
    chk("rst_cvalid", m_cvalid, 0);
    chk("rst_ack", resp_ack, 0);
    chk("rst_pready", s_pready, 0);
    chk("rst_pdata", m_pdata, 0);
    rst = 0;
    @(posedge clk); #1;

    ctrl_read(20'h00, 32'h4000, "rd_gain");
    ctrl_read(20'h04, 32'h0, "rd_ctrl");
    ctrl_read(20'h0C, 32'h0001_0000, "rd_compat");
    ctrl_read(20'h40, 32'h0, "rd_unmapped");
    ctrl_write(20'h44, 32'hDEAD_BEEF);

    chk_lat = 1;
    send_pkt(8, 32'h1234_8000, 0);
    drain();
    chk_lat = 0;
    ctrl_read(20'h08, 32'd1, "cnt_one");

    ctrl_write(20'h00, 32'h8000);
    send_pkt(1, 32'h4000_C000, 0);
    ctrl_write(20'h00, 32'h2000);
    send_pkt(1, 32'h0003_FFFD, 0);
    drain();

    ctrl_write(20'h00, 32'h4000);
    base = in_beats;
    fork
      send_pkt(6, 32'h3000_D001, 0);
      begin
        t = 0;
        while (in_beats < base + 3 && t < 100) begin @(posedge clk); #1; t++; end
        ctrl_write(20'h00, 32'h2000);
      end
    join
    send_pkt(6, 32'h3000_D001, 0);
    drain();

    ctrl_write(20'h04, 32'h1);
    rdy_mode = 1; crdy_mode = 1;
    fork
      begin
        int total, n;
        total = 0;
        while (total < 1000) begin
          n = $urandom_range(1, 16);
          send_pkt(n, 32'h0, 1);
          total += n;
        end
      end
      send_ctx(200);
    join
    rdy_mode = 0; crdy_mode = 0;
    drain();
    ctrl_write(20'h04, 32'h0);

    ctrl_write(20'h08, 32'h0);
    send_pkt(3, 32'h0100_FF00, 0);
    send_pkt(2, 32'h0100_FF00, 0);
    drain();
    ctrl_read(20'h08, 32'd2, "cnt_two");
    rdy_mode = 2;
    @(posedge clk); #1;
    send_pkt(1, 32'h0001_0001, 0);
    t = 0;
    while (!m_pvalid && t < 10) begin @(posedge clk); #1; t++; end
    chk("hold_tvalid", m_pvalid, 1);
    #1 rdy_mode = 0;
    @(posedge clk); #1;
    ctrl_write(20'h08, 32'h0);
    drain();
    ctrl_read(20'h08, 32'd0, "cnt_clear_wins");

    rdy_mode = 2;
    @(posedge clk); #1;
    s_pkeep = 1; s_plast = 0; s_pvalid = 1;
    for (int i = 0; i < 4; i++) begin
      s_pdata = $urandom;
      @(posedge clk); #1;
    end
    #2 rst = 1;
    #1;
    chk("midrst_pvalid", m_pvalid, 0);
    chk("midrst_pready", s_pready, 0);
    s_pvalid = 0;
    q_pay.delete();
    q_ctx.delete();
    m_gain = 16'h4000; m_byp = 1'b0;
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(posedge clk); #1;
    ctrl_read(20'h00, 32'h4000, "rd_gain_after_rst");
    ctrl_read(20'h08, 32'd0, "cnt_after_rst");
    send_pkt(4, 32'h7FFF_8001, 0);
    drain();
    ctrl_read(20'h08, 32'd1, "cnt_post_rst_pkt");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
